// File: rtl/bp_io_cce_tagged_if.sv
// Bus bundle for the tagged I/O CCE: LCE request in, tagged I/O command out,
// tagged I/O response in, LCE command out, plus status outputs.
interface bp_io_cce_tagged_if #(
    parameter int paddr_width_p  = 40,
    parameter int data_width_p   = 64,
    parameter int lce_id_width_p = 4,
    parameter int num_tags_p     = 4
);
    localparam int tag_width_lp = $clog2(num_tags_p);

    logic                      lce_req_v_i;
    logic                      lce_req_yumi_o;
    logic                      lce_req_store_i;
    logic [paddr_width_p-1:0]  lce_req_addr_i;
    logic [1:0]                lce_req_size_i;
    logic [data_width_p-1:0]   lce_req_data_i;
    logic [lce_id_width_p-1:0] lce_req_src_i;

    logic                      io_cmd_v_o;
    logic                      io_cmd_ready_i;
    logic                      io_cmd_store_o;
    logic [paddr_width_p-1:0]  io_cmd_addr_o;
    logic [1:0]                io_cmd_size_o;
    logic [data_width_p-1:0]   io_cmd_data_o;
    logic [tag_width_lp-1:0]   io_cmd_tag_o;

    logic                      io_resp_v_i;
    logic                      io_resp_yumi_o;
    logic [tag_width_lp-1:0]   io_resp_tag_i;
    logic [data_width_p-1:0]   io_resp_data_i;

    logic                      lce_cmd_v_o;
    logic                      lce_cmd_ready_i;
    logic                      lce_cmd_store_done_o;
    logic [lce_id_width_p-1:0] lce_cmd_dst_o;
    logic [paddr_width_p-1:0]  lce_cmd_addr_o;
    logic [1:0]                lce_cmd_size_o;
    logic [data_width_p-1:0]   lce_cmd_data_o;

    logic [tag_width_lp:0]     outstanding_o;
    logic                      error_o;

    modport slave (
        input  lce_req_v_i, lce_req_store_i, lce_req_addr_i, lce_req_size_i,
               lce_req_data_i, lce_req_src_i,
        output lce_req_yumi_o,
        output io_cmd_v_o, io_cmd_store_o, io_cmd_addr_o, io_cmd_size_o,
               io_cmd_data_o, io_cmd_tag_o,
        input  io_cmd_ready_i,
        input  io_resp_v_i, io_resp_tag_i, io_resp_data_i,
        output io_resp_yumi_o,
        output lce_cmd_v_o, lce_cmd_store_done_o, lce_cmd_dst_o, lce_cmd_addr_o,
               lce_cmd_size_o, lce_cmd_data_o,
        input  lce_cmd_ready_i,
        output outstanding_o, error_o
    );

    modport master (
        output lce_req_v_i, lce_req_store_i, lce_req_addr_i, lce_req_size_i,
               lce_req_data_i, lce_req_src_i,
        input  lce_req_yumi_o,
        input  io_cmd_v_o, io_cmd_store_o, io_cmd_addr_o, io_cmd_size_o,
               io_cmd_data_o, io_cmd_tag_o,
        output io_cmd_ready_i,
        output io_resp_v_i, io_resp_tag_i, io_resp_data_i,
        input  io_resp_yumi_o,
        input  lce_cmd_v_o, lce_cmd_store_done_o, lce_cmd_dst_o, lce_cmd_addr_o,
               lce_cmd_size_o, lce_cmd_data_o,
        output lce_cmd_ready_i,
        input  outstanding_o, error_o
    );
endinterface

// File: rtl/bp_io_cce_tagged.sv
// Tagged multi-outstanding I/O CCE: request -> io_cmd one cycle later, response -> lce_cmd one cycle later.
// Yumis are combinational; requests stall when all tags are busy or io_cmd is blocked, responses when lce_cmd is blocked.
module bp_io_cce_tagged #(
    parameter int paddr_width_p  = 40,
    parameter int data_width_p   = 64,
    parameter int lce_id_width_p = 4,
    parameter int num_tags_p     = 4
) (
    input  logic          clk_i,
    input  logic          reset_i,
    bp_io_cce_tagged_if.slave bus
);
    localparam int tag_width_lp = $clog2(num_tags_p);

    logic [num_tags_p-1:0]     valid_r;
    logic                      store_r [num_tags_p];
    logic [lce_id_width_p-1:0] src_r   [num_tags_p];
    logic [paddr_width_p-1:0]  addr_r  [num_tags_p];
    logic [1:0]                size_r  [num_tags_p];

    logic                      io_cmd_v_r;
    logic                      io_cmd_store_r;
    logic [paddr_width_p-1:0]  io_cmd_addr_r;
    logic [1:0]                io_cmd_size_r;
    logic [data_width_p-1:0]   io_cmd_data_r;
    logic [tag_width_lp-1:0]   io_cmd_tag_r;

    logic                      lce_cmd_v_r;
    logic                      lce_cmd_store_done_r;
    logic [lce_id_width_p-1:0] lce_cmd_dst_r;
    logic [paddr_width_p-1:0]  lce_cmd_addr_r;
    logic [1:0]                lce_cmd_size_r;
    logic [data_width_p-1:0]   lce_cmd_data_r;

    logic [tag_width_lp:0]     outstanding_r;
    logic                      error_r;

    logic                      any_free;
    logic [tag_width_lp-1:0]   alloc_tag;
    logic                      req_yumi;
    logic                      resp_yumi;
    logic                      resp_hit;
    logic [tag_width_lp-1:0]   resp_tag;

    // Lowest-index free tag, taken from the table as registered at cycle start.
    always_comb begin
        any_free  = 1'b0;
        alloc_tag = '0;
        for (int i = num_tags_p - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                any_free  = 1'b1;
                alloc_tag = tag_width_lp'(i);
            end
        end
    end

    assign resp_tag  = bus.io_resp_tag_i;
    assign req_yumi  = ~reset_i & bus.lce_req_v_i & any_free
                     & (~io_cmd_v_r | bus.io_cmd_ready_i);
    assign resp_yumi = ~reset_i & bus.io_resp_v_i & (~lce_cmd_v_r | bus.lce_cmd_ready_i);
    assign resp_hit  = resp_yumi & valid_r[resp_tag];

    // Alloc and free never collide: alloc picks a free tag, free needs a valid one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_r <= '0;
        end else begin
            if (resp_hit) valid_r[resp_tag]  <= 1'b0;
            if (req_yumi) valid_r[alloc_tag] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_yumi) begin
            store_r[alloc_tag] <= bus.lce_req_store_i;
            src_r[alloc_tag]   <= bus.lce_req_src_i;
            addr_r[alloc_tag]  <= bus.lce_req_addr_i;
            size_r[alloc_tag]  <= bus.lce_req_size_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            io_cmd_v_r     <= 1'b0;
            io_cmd_store_r <= 1'b0;
            io_cmd_addr_r  <= '0;
            io_cmd_size_r  <= '0;
            io_cmd_data_r  <= '0;
            io_cmd_tag_r   <= '0;
        end else if (req_yumi) begin
            io_cmd_v_r     <= 1'b1;
            io_cmd_store_r <= bus.lce_req_store_i;
            io_cmd_addr_r  <= bus.lce_req_addr_i;
            io_cmd_size_r  <= bus.lce_req_size_i;
            io_cmd_data_r  <= bus.lce_req_store_i ? bus.lce_req_data_i : '0;
            io_cmd_tag_r   <= alloc_tag;
        end else if (bus.io_cmd_ready_i) begin
            io_cmd_v_r     <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lce_cmd_v_r          <= 1'b0;
            lce_cmd_store_done_r <= 1'b0;
            lce_cmd_dst_r        <= '0;
            lce_cmd_addr_r       <= '0;
            lce_cmd_size_r       <= '0;
            lce_cmd_data_r       <= '0;
        end else if (resp_hit) begin
            lce_cmd_v_r          <= 1'b1;
            lce_cmd_store_done_r <= store_r[resp_tag];
            lce_cmd_dst_r        <= src_r[resp_tag];
            lce_cmd_addr_r       <= addr_r[resp_tag];
            lce_cmd_size_r       <= size_r[resp_tag];
            lce_cmd_data_r       <= store_r[resp_tag] ? '0 : bus.io_resp_data_i;
        end else if (bus.lce_cmd_ready_i) begin
            lce_cmd_v_r          <= 1'b0;
        end
    end

    // Unallocated-tag responses are drained but only raise the sticky error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outstanding_r <= '0;
            error_r       <= 1'b0;
        end else begin
            case ({req_yumi, resp_hit})
                2'b10:   outstanding_r <= outstanding_r + 1'b1;
                2'b01:   outstanding_r <= outstanding_r - 1'b1;
                default: outstanding_r <= outstanding_r;
            endcase
            if (resp_yumi && !valid_r[resp_tag]) error_r <= 1'b1;
        end
    end

    assign bus.lce_req_yumi_o       = req_yumi;
    assign bus.io_resp_yumi_o       = resp_yumi;
    assign bus.io_cmd_v_o           = io_cmd_v_r;
    assign bus.io_cmd_store_o       = io_cmd_store_r;
    assign bus.io_cmd_addr_o        = io_cmd_addr_r;
    assign bus.io_cmd_size_o        = io_cmd_size_r;
    assign bus.io_cmd_data_o        = io_cmd_data_r;
    assign bus.io_cmd_tag_o         = io_cmd_tag_r;
    assign bus.lce_cmd_v_o          = lce_cmd_v_r;
    assign bus.lce_cmd_store_done_o = lce_cmd_store_done_r;
    assign bus.lce_cmd_dst_o        = lce_cmd_dst_r;
    assign bus.lce_cmd_addr_o       = lce_cmd_addr_r;
    assign bus.lce_cmd_size_o       = lce_cmd_size_r;
    assign bus.lce_cmd_data_o       = lce_cmd_data_r;
    assign bus.outstanding_o        = outstanding_r;
    assign bus.error_o              = error_r;
endmodule

// File: tb/tb_bp_io_cce_tagged.sv
// Bench for bp_io_cce_tagged: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the tag table.
module tb_bp_io_cce_tagged;
    localparam int NT = 4;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    bp_io_cce_tagged_if #(.paddr_width_p(40), .data_width_p(64), .lce_id_width_p(4), .num_tags_p(NT)) bus ();

    bp_io_cce_tagged #(.paddr_width_p(40), .data_width_p(64), .lce_id_width_p(4), .num_tags_p(NT)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: tag table plus the two single-entry output registers and the sticky flag.
    logic [NT-1:0] m_val;
    logic          m_st   [NT];
    logic [3:0]    m_src  [NT];
    logic [39:0]   m_addr [NT];
    logic [1:0]    m_size [NT];
    logic        m_io_v, m_io_st;
    logic [39:0] m_io_addr;
    logic [1:0]  m_io_size;
    logic [63:0] m_io_data;
    logic [1:0]  m_io_tag;
    logic        m_lc_v, m_lc_sd;
    logic [3:0]  m_lc_dst;
    logic [39:0] m_lc_addr;
    logic [1:0]  m_lc_size;
    logic [63:0] m_lc_data;
    logic        m_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val = '0;
        m_io_v = 0; m_io_st = 0; m_io_addr = 0; m_io_size = 0; m_io_data = 0; m_io_tag = 0;
        m_lc_v = 0; m_lc_sd = 0; m_lc_dst = 0; m_lc_addr = 0; m_lc_size = 0; m_lc_data = 0;
        m_err = 0;
    endtask

    // Called at a negedge with inputs already driven: compare, advance model, wait for next negedge.
    task automatic step();
        logic any_free, ry, sy;
        logic [1:0] at, rt;
        #1;
        any_free = 0; at = 0;
        for (int i = NT - 1; i >= 0; i--) if (!m_val[i]) begin any_free = 1; at = 2'(i); end
        ry = !reset_i && bus.lce_req_v_i && any_free && (!m_io_v || bus.io_cmd_ready_i);
        sy = !reset_i && bus.io_resp_v_i && (!m_lc_v || bus.lce_cmd_ready_i);
        rt = bus.io_resp_tag_i;

        chk("req_yumi",    64'(bus.lce_req_yumi_o), 64'(ry));
        chk("resp_yumi",   64'(bus.io_resp_yumi_o), 64'(sy));
        chk("io_v",        64'(bus.io_cmd_v_o), 64'(m_io_v));
        chk("io_store",    64'(bus.io_cmd_store_o), 64'(m_io_st));
        chk("io_addr",     64'(bus.io_cmd_addr_o), 64'(m_io_addr));
        chk("io_size",     64'(bus.io_cmd_size_o), 64'(m_io_size));
        chk("io_data",     bus.io_cmd_data_o, m_io_data);
        chk("io_tag",      64'(bus.io_cmd_tag_o), 64'(m_io_tag));
        chk("lce_v",       64'(bus.lce_cmd_v_o), 64'(m_lc_v));
        chk("lce_sd",      64'(bus.lce_cmd_store_done_o), 64'(m_lc_sd));
        chk("lce_dst",     64'(bus.lce_cmd_dst_o), 64'(m_lc_dst));
        chk("lce_addr",    64'(bus.lce_cmd_addr_o), 64'(m_lc_addr));
        chk("lce_size",    64'(bus.lce_cmd_size_o), 64'(m_lc_size));
        chk("lce_data",    bus.lce_cmd_data_o, m_lc_data);
        chk("outstanding", 64'(bus.outstanding_o), 64'($countones(m_val)));
        chk("error",       64'(bus.error_o), 64'(m_err));

        if (reset_i) begin
            model_reset();
        end else begin
            if (sy) begin
                if (m_val[rt]) begin
                    m_lc_v = 1; m_lc_sd = m_st[rt]; m_lc_dst = m_src[rt];
                    m_lc_addr = m_addr[rt]; m_lc_size = m_size[rt];
                    m_lc_data = m_st[rt] ? 64'h0 : bus.io_resp_data_i;
                    m_val[rt] = 0;
                end else begin
                    m_err = 1;
                    if (bus.lce_cmd_ready_i) m_lc_v = 0;
                end
            end else if (bus.lce_cmd_ready_i) m_lc_v = 0;
            if (ry) begin
                m_val[at] = 1; m_st[at] = bus.lce_req_store_i; m_src[at] = bus.lce_req_src_i;
                m_addr[at] = bus.lce_req_addr_i; m_size[at] = bus.lce_req_size_i;
                m_io_v = 1; m_io_st = bus.lce_req_store_i; m_io_addr = bus.lce_req_addr_i;
                m_io_size = bus.lce_req_size_i; m_io_tag = at;
                m_io_data = bus.lce_req_store_i ? bus.lce_req_data_i : 64'h0;
            end else if (bus.io_cmd_ready_i) m_io_v = 0;
        end
        @(negedge clk);
    endtask

    task automatic req(input logic st, input logic [39:0] a, input logic [1:0] sz,
                       input logic [63:0] d, input logic [3:0] src);
        bus.lce_req_v_i = 1; bus.lce_req_store_i = st; bus.lce_req_addr_i = a;
        bus.lce_req_size_i = sz; bus.lce_req_data_i = d; bus.lce_req_src_i = src;
    endtask

    task automatic resp(input logic [1:0] t, input logic [63:0] d);
        bus.io_resp_v_i = 1; bus.io_resp_tag_i = t; bus.io_resp_data_i = d;
    endtask

    initial begin
        logic [1:0]  ooo_tag [4];
        logic [3:0]  ooo_src [4];
        logic [39:0] ooo_adr [4];
        bus.lce_req_v_i = 0; bus.lce_req_store_i = 0; bus.lce_req_addr_i = 0;
        bus.lce_req_size_i = 0; bus.lce_req_data_i = 0; bus.lce_req_src_i = 0;
        bus.io_cmd_ready_i = 1; bus.io_resp_v_i = 0; bus.io_resp_tag_i = 0;
        bus.io_resp_data_i = 0; bus.lce_cmd_ready_i = 1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst io_v", 64'(bus.io_cmd_v_o), 0);
        chk("rst lce_v", 64'(bus.lce_cmd_v_o), 0);
        chk("rst outstanding", 64'(bus.outstanding_o), 0);
        chk("rst error", 64'(bus.error_o), 0);
        chk("rst io_addr", 64'(bus.io_cmd_addr_o), 0);
        chk("rst req_yumi", 64'(bus.lce_req_yumi_o), 0);
        @(negedge clk);
        reset_i = 0;
        step();

        // Single load
        req(0, 40'h80_0000_1000, 2'd3, 64'h1234, 4'd2);
        step();
        bus.lce_req_v_i = 0;
        chk("load io_v", 64'(bus.io_cmd_v_o), 1);
        chk("load io_tag", 64'(bus.io_cmd_tag_o), 0);
        chk("load io_addr", 64'(bus.io_cmd_addr_o), 64'h80_0000_1000);
        chk("load io_data", bus.io_cmd_data_o, 0);
        chk("load outstanding", 64'(bus.outstanding_o), 1);
        resp(0, 64'hDEAD_BEEF);
        step();
        bus.io_resp_v_i = 0;
        chk("load lce_v", 64'(bus.lce_cmd_v_o), 1);
        chk("load lce_dst", 64'(bus.lce_cmd_dst_o), 2);
        chk("load lce_data", bus.lce_cmd_data_o, 64'hDEAD_BEEF);
        chk("load lce_sd", 64'(bus.lce_cmd_store_done_o), 0);
        chk("load outstanding after", 64'(bus.outstanding_o), 0);
        step();

        // Fill all tags and stall the fifth request
        for (int i = 0; i < NT; i++) begin
            req(0, 40'(32'h1000 * (i + 1)), 2'd2, 64'h0, 4'(i));
            step();
            chk("fill tag", 64'(bus.io_cmd_tag_o), 64'(i));
        end
        req(0, 40'h9000, 2'd1, 64'h0, 4'd9);
        step();
        chk("full yumi", 64'(bus.lce_req_yumi_o), 0);
        chk("full outstanding", 64'(bus.outstanding_o), 4);
        resp(2, 64'h22);
        step();
        bus.io_resp_v_i = 0;
        chk("free2 dst", 64'(bus.lce_cmd_dst_o), 2);
        step();
        bus.lce_req_v_i = 0;
        chk("realloc tag", 64'(bus.io_cmd_tag_o), 2);
        chk("realloc addr", 64'(bus.io_cmd_addr_o), 64'h9000);

        // Out-of-order return
        ooo_tag = '{2'd3, 2'd0, 2'd2, 2'd1};
        ooo_src = '{4'd3, 4'd0, 4'd9, 4'd1};
        ooo_adr = '{40'h4000, 40'h1000, 40'h9000, 40'h2000};
        for (int i = 0; i < 4; i++) begin
            resp(ooo_tag[i], 64'hA0 + 64'(ooo_tag[i]));
            step();
            chk("ooo dst", 64'(bus.lce_cmd_dst_o), 64'(ooo_src[i]));
            chk("ooo addr", 64'(bus.lce_cmd_addr_o), 64'(ooo_adr[i]));
            chk("ooo data", bus.lce_cmd_data_o, 64'hA0 + 64'(ooo_tag[i]));
        end
        bus.io_resp_v_i = 0;
        step();

        // Store
        req(1, 40'h20, 2'd0, 64'h55, 4'd7);
        step();
        bus.lce_req_v_i = 0;
        chk("store io_store", 64'(bus.io_cmd_store_o), 1);
        chk("store io_data", bus.io_cmd_data_o, 64'h55);
        resp(0, 64'hFF);
        step();
        bus.io_resp_v_i = 0;
        chk("store lce_sd", 64'(bus.lce_cmd_store_done_o), 1);
        chk("store lce_data", bus.lce_cmd_data_o, 0);
        step();

        // io_cmd backpressure
        bus.io_cmd_ready_i = 0;
        req(0, 40'hA0, 2'd1, 64'h0, 4'd3);
        step();
        req(0, 40'hB0, 2'd1, 64'h0, 4'd4);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp io_addr", 64'(bus.io_cmd_addr_o), 64'hA0);
            chk("bp outstanding", 64'(bus.outstanding_o), 1);
        end
        bus.lce_req_v_i = 0;
        bus.io_cmd_ready_i = 1;
        step();

        // lce_cmd backpressure
        bus.lce_cmd_ready_i = 0;
        resp(0, 64'h77);
        step();
        #1;
        chk("bp resp_yumi", 64'(bus.io_resp_yumi_o), 0);
        step();
        bus.io_resp_v_i = 0;
        bus.lce_cmd_ready_i = 1;
        step();

        // Unallocated tag
        resp(1, 64'h11);
        #1;
        chk("bad resp_yumi", 64'(bus.io_resp_yumi_o), 1);
        step();
        bus.io_resp_v_i = 0;
        chk("bad error", 64'(bus.error_o), 1);
        chk("bad lce_v", 64'(bus.lce_cmd_v_o), 0);
        step(); step();
        chk("bad error sticky", 64'(bus.error_o), 1);

        // Reset with two outstanding
        req(0, 40'hC0, 2'd3, 64'h0, 4'd5);
        step(); step();
        bus.lce_req_v_i = 0;
        step();
        chk("pre-rst outstanding", 64'(bus.outstanding_o), 2);
        reset_i = 1;
        step();
        reset_i = 0;
        chk("mid-rst outstanding", 64'(bus.outstanding_o), 0);
        chk("mid-rst io_v", 64'(bus.io_cmd_v_o), 0);
        chk("mid-rst lce_v", 64'(bus.lce_cmd_v_o), 0);
        chk("mid-rst error", 64'(bus.error_o), 0);
        chk("mid-rst lce_data", bus.lce_cmd_data_o, 0);
        resp(0, 64'h5);
        step();
        bus.io_resp_v_i = 0;
        chk("stale tag error", 64'(bus.error_o), 1);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            bus.lce_req_v_i     = ($urandom_range(0, 9) < 7);
            bus.lce_req_store_i = 1'($urandom());
            bus.lce_req_addr_i  = {8'($urandom()), 32'($urandom())};
            bus.lce_req_size_i  = 2'($urandom());
            bus.lce_req_data_i  = {$urandom(), $urandom()};
            bus.lce_req_src_i   = 4'($urandom());
            bus.io_cmd_ready_i  = ($urandom_range(0, 9) < 7);
            bus.lce_cmd_ready_i = ($urandom_range(0, 9) < 7);
            bus.io_resp_data_i  = {$urandom(), $urandom()};
            bus.io_resp_v_i     = 0;
            if (m_val != 0 && $urandom_range(0, 9) < 6) begin
                logic [1:0] t;
                do t = 2'($urandom()); while (!m_val[t]);
                bus.io_resp_v_i = 1; bus.io_resp_tag_i = t;
            end else if ($urandom_range(0, 49) == 0) begin
                bus.io_resp_v_i = 1; bus.io_resp_tag_i = 2'($urandom());
            end
            reset_i = ($urandom_range(0, 399) == 0);
            step();
        end
        reset_i = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
